gpu_cmd_queue: RTL

GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

---
 rtl/gpu_cmd_queue.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_queue.sv
// rtl/gpu_cmd_queue.sv - raster command FIFO with a single-outstanding GPU issue FSM
// Entries are popped on the IDLE->ISSUE edge; the GPU sees a one-cycle execute request.

package gpu_cmd_queue_pkg;
    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_PIXEL     = 3'd1,
        CMD_LINE      = 3'd2,
        CMD_RECT      = 3'd3,
        CMD_FILL_RECT = 3'd4,
        CMD_CLEAR     = 3'd5
    } raster_command_t;
endpackage

module gpu_cmd_queue
    import gpu_cmd_queue_pkg::*;
#(
    parameter int COORD_W       = 8,
    parameter int COLOUR_W      = 3,
    parameter int DEPTH         = 4,
    parameter int BUSY_WAIT_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_sync,
    input  raster_command_t             cmd_in,
    input  logic [COORD_W-1:0]          x0_in,
    input  logic [COORD_W-1:0]          y0_in,
    input  logic [COORD_W-1:0]          x1_in,
    input  logic [COORD_W-1:0]          y1_in,
    input  logic [COLOUR_W-1:0]         colour_in,
    input  logic                        push,
    input  logic                        flush,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic                        idle,
    output raster_command_t             gpu_command,
    output logic [COORD_W-1:0]          gpu_x0,
    output logic [COORD_W-1:0]          gpu_y0,
    output logic [COORD_W-1:0]          gpu_x1,
    output logic [COORD_W-1:0]          gpu_y1,
    output logic [COLOUR_W-1:0]         gpu_colour,
    output logic                        gpu_execute_request,
    input  logic                        gpu_busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(BUSY_WAIT_MAX) + 1;
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT_MAX - 1);

    typedef struct packed {
        raster_command_t       cmd;
        logic [COORD_W-1:0]    x0;
        logic [COORD_W-1:0]    y0;
        logic [COORD_W-1:0]    x1;
        logic [COORD_W-1:0]    y1;
        logic [COLOUR_W-1:0]   colour;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_overflow;
    logic               r_busy_q;
    logic [WAIT_W-1:0]  r_wait_cnt;
    entry_t             r_gpu;
    logic               r_req;
    state_t             r_state;
    state_t             w_state_next;

    logic               w_full;
    logic               w_push_ok;
    logic               w_pop;
    entry_t             w_wr_entry;

    assign w_full     = (r_level == LVL_FULL);
    // Space is judged on the registered level only, so a same-cycle pop never admits a push.
    assign w_push_ok  = push && !w_full && !flush;
    assign w_pop      = (w_state_next == S_ISSUE);
    assign w_wr_entry = '{cmd: cmd_in, x0: x0_in, y0: y0_in, x1: x1_in, y1: y1_in,
                          colour: colour_in};

    always_ff @(posedge clk) begin
        if (!rst_sync && w_push_ok) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (push && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_level != '0) && !gpu_busy && !flush) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (gpu_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!gpu_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_gpu      <= '0;
            r_req      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= w_pop;
            if (w_pop) begin
                r_gpu <= r_mem[r_rd_ptr];
            end
            if (r_state == S_WAIT_BUSY) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // idle uses a registered copy of gpu_busy so it has no combinational path from the input.
    always_ff @(posedge clk) begin
        r_busy_q <= gpu_busy;
    end

    assign full                = w_full;
    assign level               = r_level;
    assign overflow            = r_overflow;
    assign idle                = (r_level == '0) && (r_state == S_IDLE) && !r_busy_q;
    assign gpu_command         = r_gpu.cmd;
    assign gpu_x0              = r_gpu.x0;
    assign gpu_y0              = r_gpu.y0;
    assign gpu_x1              = r_gpu.x1;
    assign gpu_y1              = r_gpu.y1;
    assign gpu_colour          = r_gpu.colour;
    assign gpu_execute_request = r_req;

endmodule
